// File: rtl/dop_packer.sv
`default_nettype none
// ============================================================================
// Module   : dop_packer
// Brief    : Packs stereo DSD bits into DoP 48-bit frames ({marker, dsd16} per
//            channel) and queues them in a 4-entry first-word-fall-through FIFO.
//            Optional macro DOP_SILENCE_EN substitutes the DSD silence pattern
//            when mute is high at word completion.
// Revision : 1.0 - initial release
// ============================================================================
module dop_packer (
    input  logic        dsd_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        dsd_l,
    input  logic        dsd_r,
    input  logic        mute,
    input  logic        frame_ready,
    output logic [47:0] frame_data,
    output logic        frame_valid,
    output logic [2:0]  fifo_level,
    output logic        drop
);

    localparam int         DEPTH          = 4;
    localparam logic [7:0] c_MARKER_EVEN  = 8'h05;
    localparam logic [7:0] c_MARKER_ODD   = 8'hFA;
    localparam logic [15:0] c_SILENCE     = 16'h6969;
    localparam logic [2:0] c_LEVEL_FULL   = 3'd4;

    logic [3:0]  r_bit_cnt;
    // Only the 15 earlier bits are stored; the 16th is taken live on the completion edge.
    logic [14:0] r_shift_l;
    logic [14:0] r_shift_r;
    logic        r_marker_odd;

    logic [47:0] r_mem [DEPTH];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_level;
    logic        r_drop;

    logic [15:0] w_word_l;
    logic [15:0] w_word_r;
    logic [15:0] w_dsd16_l;
    logic [15:0] w_dsd16_r;
    logic [7:0]  w_marker;
    logic [47:0] w_frame;
    logic        w_complete;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign w_word_l = {r_shift_l, dsd_l};
    assign w_word_r = {r_shift_r, dsd_r};

`ifdef DOP_SILENCE_EN
    assign w_dsd16_l = mute ? c_SILENCE : w_word_l;
    assign w_dsd16_r = mute ? c_SILENCE : w_word_r;
`else
    logic w_unused_mute;
    logic [15:0] w_unused_silence;
    assign w_unused_mute    = mute;
    assign w_unused_silence = c_SILENCE;
    assign w_dsd16_l        = w_word_l;
    assign w_dsd16_r        = w_word_r;
`endif

    assign w_marker   = r_marker_odd ? c_MARKER_ODD : c_MARKER_EVEN;
    assign w_frame    = {w_marker, w_dsd16_l, w_marker, w_dsd16_r};
    assign w_complete = enable && (r_bit_cnt == 4'd15);
    assign w_full     = (r_level == c_LEVEL_FULL);
    assign w_pop      = (r_level != 3'd0) && frame_ready;
    // When full, a simultaneous pop frees the slot the push is about to overwrite.
    assign w_push     = w_complete && (!w_full || w_pop);

    always_ff @(posedge dsd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= 4'd0;
            r_shift_l    <= '0;
            r_shift_r    <= '0;
            r_marker_odd <= 1'b0;
        end else if (!enable) begin
            r_bit_cnt    <= 4'd0;
            r_shift_l    <= '0;
            r_shift_r    <= '0;
            r_marker_odd <= 1'b0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_shift_l <= {r_shift_l[13:0], dsd_l};
            r_shift_r <= {r_shift_r[13:0], dsd_r};
            if (w_push) begin
                r_marker_odd <= !r_marker_odd;
            end
        end
    end

    always_ff @(posedge dsd_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_level  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_frame;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge dsd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= 1'b0;
        end else if (w_complete && w_full && !w_pop) begin
            r_drop <= 1'b1;
        end
    end

    assign frame_valid = (r_level != 3'd0);
    assign frame_data  = frame_valid ? r_mem[r_rd_ptr] : 48'h0;
    assign fifo_level  = r_level;
    assign drop        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_dop_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dop_packer
// Brief    : Self-checking bench for dop_packer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dop_packer;

    logic        dsd_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        dsd_l = 1'b0;
    logic        dsd_r = 1'b0;
    logic        mute = 1'b0;
    logic        frame_ready = 1'b0;
    logic [47:0] frame_data;
    logic        frame_valid;
    logic [2:0]  fifo_level;
    logic        drop;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits gathered so far, frames queued, pushes since enable rise.
    logic [47:0] m_fifo[$];
    int          m_nbits;
    int          m_acc_l;
    int          m_acc_r;
    int          m_pushes;
    bit          m_drop;

    dop_packer dut (
        .dsd_clk     (dsd_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .dsd_l       (dsd_l),
        .dsd_r       (dsd_r),
        .mute        (mute),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .fifo_level  (fifo_level),
        .drop        (drop)
    );

    always #5 dsd_clk = ~dsd_clk;

    task automatic model_clear();
        m_fifo.delete();
        m_nbits  = 0;
        m_acc_l  = 0;
        m_acc_r  = 0;
        m_pushes = 0;
        m_drop   = 1'b0;
    endtask

    function automatic logic [52:0] m_outs();
        logic [47:0] head;
        logic [2:0]  lvl;
        head = (m_fifo.size() != 0) ? m_fifo[0] : 48'h0;
        lvl  = 3'(m_fifo.size());
        return {m_fifo.size() != 0, lvl, m_drop, head};
    endfunction

    // Drive one cycle of inputs, advance the model across the rising edge, settle.
    task automatic step(input bit en, input bit l, input bit r, input bit mu, input bit rdy);
        int          sz;
        bit          pop;
        bit          done;
        logic [15:0] wl;
        logic [15:0] wr;
        logic [7:0]  mk;
        enable      = en;
        dsd_l       = l;
        dsd_r       = r;
        mute        = mu;
        frame_ready = rdy;
        @(posedge dsd_clk);
        sz   = m_fifo.size();
        pop  = (sz != 0) && rdy;
        done = 1'b0;
        wl   = 16'h0;
        wr   = 16'h0;
        if (!en) begin
            m_nbits  = 0;
            m_acc_l  = 0;
            m_acc_r  = 0;
            m_pushes = 0;
        end else begin
            m_acc_l = (m_acc_l * 2 + int'(l)) % 65536;
            m_acc_r = (m_acc_r * 2 + int'(r)) % 65536;
            m_nbits++;
            if (m_nbits == 16) begin
                done    = 1'b1;
                m_nbits = 0;
                wl      = 16'(m_acc_l);
                wr      = 16'(m_acc_r);
`ifdef DOP_SILENCE_EN
                if (mu) begin
                    wl = 16'h6969;
                    wr = 16'h6969;
                end
`endif
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (done) begin
            if (sz < 4 || pop) begin
                mk = (m_pushes % 2 == 0) ? 8'h05 : 8'hFA;
                m_fifo.push_back({mk, wl, mk, wr});
                m_pushes++;
            end else begin
                m_drop = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        model_clear();
        @(posedge dsd_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_tests++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++;
        if (frame_data !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", frame_data); end
        n_tests++;
        if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop); end
        @(posedge dsd_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_pattern();
        int vcnt = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i % 2) == 0, 1'b1, 1'b0, 1'b1);
            if (frame_valid === 1'b1) vcnt++;
            if (i == 15) begin
                n_tests++;
                if (frame_data !== {8'h05, 16'hAAAA, 8'h05, 16'hFFFF}) begin
                    n_fail++; $display("FAIL basic_frame0: got %h want 05aaaa05ffff", frame_data);
                end
            end
            if (i == 31) begin
                n_tests++;
                if (frame_data !== {8'hFA, 16'hAAAA, 8'hFA, 16'hFFFF}) begin
                    n_fail++; $display("FAIL basic_frame1: got %h want faaaaafaffff", frame_data);
                end
            end
            n_tests++;
            if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
                n_fail++; $display("FAIL basic_cycle%0d: got %h want %h", i, {frame_valid, fifo_level, drop, frame_data}, m_outs());
            end
        end
        n_tests++;
        if (vcnt != 2) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 2", vcnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_mk [4];
        exp_mk = '{8'h05, 8'hFA, 8'h05, 8'hFA};
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            if (i == 78) begin
                n_tests++;
                if (drop !== 1'b0) begin n_fail++; $display("FAIL ovf_drop_early: got %b want 0", drop); end
            end
            n_tests++;
            if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
                n_fail++; $display("FAIL ovf_cycle%0d: got %h want %h", i, {frame_valid, fifo_level, drop, frame_data}, m_outs());
            end
        end
        n_tests++;
        if (fifo_level !== 3'd4 || drop !== 1'b1) begin
            n_fail++; $display("FAIL ovf_full: got level %0d drop %b want 4 1", fifo_level, drop);
        end
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                n_tests++;
                if (frame_data[47:40] !== exp_mk[i] || frame_data[23:16] !== exp_mk[i]) begin
                    n_fail++; $display("FAIL ovf_marker%0d: got %h want %h", i, frame_data[47:40], exp_mk[i]);
                end
            end
            step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        end
        n_tests++;
        if (frame_valid !== 1'b1 || frame_data[47:40] !== 8'h05) begin
            n_fail++; $display("FAIL ovf_next_marker: got valid %b marker %h want 1 05", frame_valid, frame_data[47:40]);
        end
        n_tests++;
        if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
            n_fail++; $display("FAIL ovf_after_drain: got %h want %h", {frame_valid, fifo_level, drop, frame_data}, m_outs());
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 79; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        n_tests++;
        if (fifo_level !== 3'd4 || drop !== 1'b0) begin
            n_fail++; $display("FAIL fpp_prefill: got level %0d drop %b want 4 0", fifo_level, drop);
        end
        step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        n_tests++;
        if (fifo_level !== 3'd4 || drop !== 1'b0) begin
            n_fail++; $display("FAIL fpp_level_drop: got level %0d drop %b want 4 0", fifo_level, drop);
        end
        n_tests++;
        if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
            n_fail++; $display("FAIL fpp_state: got %h want %h", {frame_valid, fifo_level, drop, frame_data}, m_outs());
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
            n_fail++; $display("FAIL fpp_drained: got %h want %h", {frame_valid, fifo_level, drop, frame_data}, m_outs());
        end
    endtask

    task automatic test_enable_abort();
        logic [15:0] pat = 16'hF0F0;
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, pat[15-i], 1'($urandom), 1'b0, 1'b0);
            if (i == 14) begin
                n_tests++;
                if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL abort_early_push: got valid %b want 0", frame_valid); end
            end
        end
        n_tests++;
        if (frame_data[47:24] !== {8'h05, 16'hF0F0} || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL abort_frame: got %h level %0d want 05f0f0 level 1", frame_data[47:24], fifo_level);
        end
        n_tests++;
        if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
            n_fail++; $display("FAIL abort_state: got %h want %h", {frame_valid, fifo_level, drop, frame_data}, m_outs());
        end
    endtask

    task automatic test_mute();
        logic [15:0] wl = 16'h0;
        logic [15:0] wr = 16'h0;
        logic [15:0] el;
        logic [15:0] er;
        bit l;
        bit r;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            l = 1'($urandom); r = 1'($urandom);
            wl = {wl[14:0], l}; wr = {wr[14:0], r};
            step(1'b1, l, r, i == 15, 1'b0);
        end
`ifdef DOP_SILENCE_EN
        el = 16'h6969; er = 16'h6969;
`else
        el = wl; er = wr;
`endif
        n_tests++;
        if (frame_data !== {8'h05, el, 8'h05, er}) begin
            n_fail++; $display("FAIL mute_frame0: got %h want %h", frame_data, {8'h05, el, 8'h05, er});
        end
        for (int i = 0; i < 16; i++) begin
            l = 1'($urandom); r = 1'($urandom);
            wl = {wl[14:0], l}; wr = {wr[14:0], r};
            step(1'b1, l, r, i != 15, i == 0);
        end
        n_tests++;
        if (frame_data !== {8'hFA, wl, 8'hFA, wr} || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL mute_frame1: got %h want %h", frame_data, {8'hFA, wl, 8'hFA, wr});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 37; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        n_tests++;
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL rmid_prefill: got %0d want 2", fifo_level); end
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (frame_valid !== 1'b0 || fifo_level !== 3'd0 || drop !== 1'b0 || frame_data !== 48'h0) begin
            n_fail++; $display("FAIL rmid_async: got valid %b level %0d drop %b data %h want 0 0 0 0", frame_valid, fifo_level, drop, frame_data);
        end
        @(posedge dsd_clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        n_tests++;
        if (frame_data[47:40] !== 8'h05 || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL rmid_next: got marker %h level %0d want 05 1", frame_data[47:40], fifo_level);
        end
        n_tests++;
        if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
            n_fail++; $display("FAIL rmid_state: got %h want %h", {frame_valid, fifo_level, drop, frame_data}, m_outs());
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 24) != 0, 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0);
            n_tests++;
            if ({frame_valid, fifo_level, drop, frame_data} !== m_outs()) begin
                n_fail++;
                errs++;
                if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, {frame_valid, fifo_level, drop, frame_data}, m_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pattern();
        test_overflow();
        test_reset();
        test_full_push_pop();
        test_enable_abort();
        test_mute();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dop_packer.md
DOP_PACKER -- requirements
Module: dop_packer

Interface
REQ-001 SHALL: dsd_clk  in  1  DSD bit clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: enable  in  1  high = pack; low = packer idle, partial word discarded.
REQ-004 SHALL: dsd_l  in  1  left-channel DSD bit, sampled on rising dsd_clk.
REQ-005 SHALL: dsd_r  in  1  right-channel DSD bit, sampled on rising dsd_clk.
REQ-006 SHALL: mute  in  1  substitute the DSD silence pattern; sampled at word completion; present in both builds.
REQ-007 SHALL: frame_ready  in  1  downstream accepts the head frame.
REQ-008 SHALL: frame_data  out  48  head frame {L[23:0], R[23:0]}; each half is {marker[7:0], dsd16[15:0]}.
REQ-009 SHALL: frame_valid  out  1  FIFO non-empty.
REQ-010 SHALL: fifo_level  out  3  FIFO occupancy, 0..4.
REQ-011 SHALL: drop  out  1  sticky flag, set when a completed frame is lost to a full FIFO.

Function
REQ-012 SHALL: packer: per-channel 16-bit shift register, MSB-first; first bit sampled lands in bit 15.
REQ-013 SHALL: 4-bit bit counter, 0..15; it increments on each rising edge while enable=1 and wraps 15->0.
REQ-014 SHALL: word completion is the edge on which the counter is 15; the frame is built from the 15 prior bits plus the bit sampled on that edge.
REQ-015 SHALL: DoP marker: the same 8-bit marker is used for both halves of a frame; the first frame after reset or enable rise is 0x05; the marker alternates 0x05/0xFA and toggles only on a successful push.
REQ-016 SHALL: FIFO: 4 entries x 48 bits, first-word-fall-through; frame_data always shows the head entry; frame_data is 0 when empty.
REQ-017 SHALL: push at word completion; the frame is visible on frame_valid/frame_data after that same edge, so latency is 0 cycles after the 16th bit when the FIFO was empty.
REQ-018 SHALL: pop on a rising edge with frame_valid=1 and frame_ready=1; frame_ready while empty has no effect.
REQ-019 SHALL: push while full with no pop: frame discarded, drop set to 1, marker not toggled, level stays 4.
REQ-020 SHALL: simultaneous push and pop while full: both performed, level stays 4, no drop.
REQ-021 SHALL: simultaneous push and pop at 1..3: level unchanged; at 0, push only.
REQ-022 SHALL: enable low: counter, shift registers and marker cleared (marker returns to 0x05 on next frame); FIFO contents and pops unaffected; drop held.
REQ-023 SHALL: enable low on a would-be completion edge: no push.
REQ-024 SHALL: the counter restarts at 0 on the first edge with enable=1.

Reset
REQ-025 SHALL: reset_n=0 asynchronously clears counter, shift registers, FIFO pointers and FIFO contents; frame_valid=0, frame_data=0, fifo_level=0, drop=0, next marker=0x05.
REQ-026 SHALL: reset asserted mid-word or mid-handshake discards all pending data; no frame is emitted from pre-reset bits.
REQ-027 SHALL: drop is cleared only by reset.

Configuration
REQ-028 SHALL: macro DOP_SILENCE_EN, defined: if mute=1 at word completion, both dsd16 fields are 16'h6969; markers and counters behave unchanged.
REQ-029 SHALL: macro DOP_SILENCE_EN, undefined: mute is ignored and captured bits are always used.

Verification
REQ-030 SHALL: enable=1, dsd_l=1010... repeating, dsd_r=constant 1, frame_ready=1, 32 bits -> frames {05AAAA,05FFFF} then {FAAAAA,FAFFFF}; frame_valid high 1 cycle per frame.
REQ-031 SHALL: frame_ready=0, 5 words completed -> fifo_level=4, drop=1 after the 5th completion; after draining, the 4 frames carry markers 05,FA,05,FA; the next pushed frame carries 05.
REQ-032 SHALL: FIFO full, frame_ready=1 on the completion edge -> push and pop both occur, level=4, drop=0.
REQ-033 SHALL: enable dropped after 7 bits, re-raised, 16 bits of 0xF0F0 fed -> one frame {05F0F0,...}; the 7 bits do not appear.
REQ-034 SHALL: with DOP_SILENCE_EN defined, mute=1 at a completion edge -> frame {05 or FA, 6969} on both halves; without the macro, the captured data is used.
REQ-035 SHALL: reset_n pulsed low mid-word with 2 frames queued -> frame_valid=0, fifo_level=0, drop=0 immediately; the next frame's marker is 0x05.
